sd_cmd_host: RTL and testbench
==============================

Name: sd_cmd_host

Overview:
Host-side SD command-line initiator: the counterpart of the card-side command responder in the SD model.
- On request, serialises a 48-bit command frame with CRC7 onto the CMD line.
- Releases the line, waits for the card's response, deserialises and checks it (CRC7, index, framing, timeout).
- Sits between the SDHCI command register logic and the CMD pad or SD model wrapper.

Parameters:
TIMEOUT_CYCLES, 64, max clocks after the command end bit to wait for a response start bit (NCR)
GAP_CYCLES, 8, clocks CMD stays released after the frame or response before done (NCC/NRC)

Ports:
sd_clk_i  in  1  SD clock; all logic on rising edge
rst_i  in  1  synchronous, active-high reset
start_i  in  1  command request; accepted only in IDLE
cmd_index_i  in  6  command index; sampled on accept
cmd_arg_i  in  32  argument; sampled on accept
resp_type_i  in  2  00 none, 01 R48 checked, 10 R48 unchecked (R3), 11 R136; sampled on accept
busy_o  out  1  high from cycle after accept through the done cycle
done_o  out  1  one-cycle completion pulse
resp_o  out  120  response payload
timeout_err_o  out  1  no start bit within TIMEOUT_CYCLES
crc_err_o  out  1  response CRC7 mismatch
end_bit_err_o  out  1  response end bit was 0
index_err_o  out  1  R48-checked index mismatch, or transmission bit not 0
cmd_en_o  out  1  host drives CMD
cmd_o  out  1  CMD output bit
cmd_i  in  1  sampled CMD line; pulled high when released

Behaviour:
- Reset values: busy_o=0, done_o=0, cmd_en_o=0, cmd_o=1, resp_o=0, all error flags=0, state IDLE.
- Reset mid-operation aborts immediately to this reset state; no done pulse.
- States: IDLE -> TX -> (WAIT_START -> RX) -> GAP -> DONE -> IDLE.
- IDLE:
  - start_i=1 in cycle 0 latches the inputs, clears the error flags and resp_o, and moves to TX.
  - start_i while not IDLE is ignored.
- TX:
  - Cycles 1..48 drive the frame MSB first with cmd_en_o=1: start 0, transmission 1, index[5:0], arg[31:0], CRC7[6:0], end 1.
  - CRC7 polynomial is x^7+x^3+1, initial value 0, computed over the first 40 bits.
- After TX, cmd_en_o=0 and cmd_o=1 from cycle 49.
  - resp_type 00: go to GAP.
  - Otherwise: go to WAIT_START.
- WAIT_START:
  - A counter starts at 0 in cycle 49 and increments each cycle cmd_i=1.
  - cmd_i=0 moves to RX; that cycle counts as response bit 47 or 135.
  - Counter reaching TIMEOUT_CYCLES sets timeout_err_o and moves directly to DONE.
- RX (R48): shift the remaining 47 bits.
  - Check transmission bit=0 and, for type 01 only, index==cmd_index; failure sets index_err_o.
  - CRC7 is over bits 47..8, checked for type 01 only.
  - resp_o[31:0] = bits 39..8; upper bits 0.
- RX (R136): shift the remaining 135 bits.
  - Bits 133..128 are not checked.
  - CRC7 is over bits 127..8 and checked against bits 7..1.
  - resp_o[119:0] = bits 127..8.
- End bit: in all response types, end bit 0 sets end_bit_err_o.
- GAP: GAP_CYCLES cycles with CMD released, then DONE.
- DONE: done_o=1 and busy_o=1 for that one cycle, then IDLE.
  - resp_o and error flags hold until the next accepted start.
- start_i asserted in the DONE cycle is ignored; it is accepted in the following IDLE cycle.
- cmd_i toggling during TX is ignored.

Decomposition:
- Package sd_cmd_pkg holds:
  - resp_type_e enum (RESP_NONE, RESP_R48, RESP_R48_NOCRC, RESP_R136)
  - state_e enum
  - CRC7_POLY = 7'h09
  - frame/response length constants 48 and 136
- Sub-module sd_crc7: serial CRC7 with clr, en, bit inputs and crc[6:0] output, one instance shared between TX and RX.

Test Plan:
- CMD0, arg 0x0, resp none -> cmd_o over cycles 1..48 = 0x400000000095; cmd_en_o low from 49; done_o at cycle 57; no errors.
- CMD8, arg 0x1AA, R48 -> frame 0x48000001AA87; bench model replies 0x08000001AA13 after 5 idle cycles -> resp_o=0x1AA; no errors.
- R48 reply with one flipped CRC bit -> crc_err_o=1 at done; other flags 0.
- R48 reply with index 9 for CMD8 -> index_err_o=1; same reply with resp_type 10 -> no error.
- No card reply, resp_type 01 -> timeout_err_o=1 and done_o at cycle 49+64; cmd_en_o stays 0.
- R136 reply with known CID and valid CRC7 -> resp_o equals CID[127:8]; then rst_i asserted mid-TX -> cmd_en_o=0, busy_o=0 next cycle, no done_o.

Source files
------------

// File: rtl/sd_cmd_pkg.sv
// sd_cmd_pkg: shared types and constants for the SD host command path
package sd_cmd_pkg;
  typedef enum logic [1:0] {
    RESP_NONE      = 2'b00,
    RESP_R48       = 2'b01,
    RESP_R48_NOCRC = 2'b10,
    RESP_R136      = 2'b11
  } resp_type_e;
  typedef enum logic [2:0] {
    ST_IDLE, ST_TX, ST_WAIT_START, ST_RX, ST_GAP, ST_DONE
  } state_e;
  localparam logic [6:0] CRC7_POLY = 7'h09;
  localparam int FRAME_LEN = 48;
  localparam int R136_LEN = 136;
endpackage

// File: rtl/sd_crc7.sv
// sd_crc7: serial CRC7 (x^7+x^3+1); clr zeroes, en shifts in din
module sd_crc7
  import sd_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);
  always_ff @(posedge clk)
    if (clr) crc <= '0;
    else if (en) crc <= {crc[5:0], 1'b0} ^ ((crc[6] ^ din) ? CRC7_POLY : 7'h00);
endmodule

// File: rtl/sd_cmd_host.sv
// sd_cmd_host: SD CMD-line initiator; sends 48-bit command, receives and checks R48/R136 response
module sd_cmd_host
  import sd_cmd_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int GAP_CYCLES = 8
) (
  input  logic         sd_clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [5:0]   cmd_index_i,
  input  logic [31:0]  cmd_arg_i,
  input  logic [1:0]   resp_type_i,
  output logic         busy_o,
  output logic         done_o,
  output logic [119:0] resp_o,
  output logic         timeout_err_o,
  output logic         crc_err_o,
  output logic         end_bit_err_o,
  output logic         index_err_o,
  output logic         cmd_en_o,
  output logic         cmd_o,
  input  logic         cmd_i
);
  state_e       state;
  resp_type_e   rtype;
  logic [5:0]   idx;
  logic [46:0]  tx_sr;
  logic [126:0] rx_sr;
  logic [15:0]  cnt;
  logic [15:0]  rx_len;
  logic [15:0]  rx_idx;
  logic         crc_clr;
  logic         crc_en;
  logic         crc_bit;
  logic [6:0]   crc;
  sd_crc7 u_crc (.clk(sd_clk_i), .clr(crc_clr), .en(crc_en), .din(crc_bit), .crc(crc));
  // tx: the CRC sees each frame bit on the edge that places it on cmd_o, so it is
  // complete by the edge that must place the first CRC bit. Bit 47 (start, 0) is a
  // no-op on a cleared CRC, so clearing on accept covers it.
  // rx: rx_idx is the response bit sampled on this edge; only bits 127/47..8 feed the CRC.
  always_comb begin
    rx_len = (rtype == RESP_R136) ? 16'(R136_LEN) : 16'(FRAME_LEN);
    rx_idx = rx_len - 16'd1 - cnt;
    crc_clr = rst_i || (state == ST_IDLE && start_i) || (state == ST_TX && cnt == 16'(FRAME_LEN));
    crc_en = (state == ST_TX && cnt < 16'd40) || (state == ST_RX && rx_idx >= 16'd8 && rx_idx <= 16'd127);
    crc_bit = (state == ST_TX) ? tx_sr[46] : cmd_i;
  end
  always_ff @(posedge sd_clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      rtype <= RESP_NONE;
      idx <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      cnt <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      resp_o <= '0;
      timeout_err_o <= 1'b0;
      crc_err_o <= 1'b0;
      end_bit_err_o <= 1'b0;
      index_err_o <= 1'b0;
      cmd_en_o <= 1'b0;
      cmd_o <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: if (start_i) begin
          state <= ST_TX;
          rtype <= resp_type_e'(resp_type_i);
          idx <= cmd_index_i;
          tx_sr <= {1'b1, cmd_index_i, cmd_arg_i, 7'd0, 1'b1};
          cnt <= 16'd1;
          busy_o <= 1'b1;
          resp_o <= '0;
          timeout_err_o <= 1'b0;
          crc_err_o <= 1'b0;
          end_bit_err_o <= 1'b0;
          index_err_o <= 1'b0;
          cmd_en_o <= 1'b1;
          cmd_o <= 1'b0;
        end
        ST_TX: begin
          cnt <= cnt + 16'd1;
          if (cnt == 16'(FRAME_LEN)) begin
            cmd_en_o <= 1'b0;
            cmd_o <= 1'b1;
            cnt <= '0;
            state <= (rtype == RESP_NONE) ? ST_GAP : ST_WAIT_START;
          end else if (cnt == 16'd40) begin
            cmd_o <= crc[6];
            tx_sr <= {crc[5:0], 1'b1, 40'd0};
          end else begin
            cmd_o <= tx_sr[46];
            tx_sr <= {tx_sr[45:0], 1'b0};
          end
        end
        ST_WAIT_START: begin
          if (!cmd_i) begin
            state <= ST_RX;
            cnt <= 16'd1;
          end else if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
            timeout_err_o <= 1'b1;
            done_o <= 1'b1;
            state <= ST_DONE;
          end else cnt <= cnt + 16'd1;
        end
        ST_RX: begin
          rx_sr <= {rx_sr[125:0], cmd_i};
          cnt <= cnt + 16'd1;
          // on the end-bit edge, rx_sr[j-1] holds response bit j
          if (rx_idx == 16'd0) begin
            state <= ST_GAP;
            cnt <= '0;
            end_bit_err_o <= !cmd_i;
            if (rtype == RESP_R136) begin
              resp_o <= rx_sr[126:7];
              crc_err_o <= crc != rx_sr[6:0];
            end else begin
              resp_o <= {88'd0, rx_sr[38:7]};
              crc_err_o <= (rtype == RESP_R48) && (crc != rx_sr[6:0]);
              index_err_o <= rx_sr[45] || ((rtype == RESP_R48) && (rx_sr[44:39] != idx));
            end
          end
        end
        ST_GAP: begin
          if (cnt == 16'(GAP_CYCLES - 1)) begin
            done_o <= 1'b1;
            state <= ST_DONE;
          end else cnt <= cnt + 16'd1;
        end
        ST_DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sd_cmd_host.sv
// tb_sd_cmd_host: directed self-checking bench for sd_cmd_host with a simple card reply model
module tb_sd_cmd_host;
  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         start_i = 1'b0;
  logic [5:0]   cmd_index_i = '0;
  logic [31:0]  cmd_arg_i = '0;
  logic [1:0]   resp_type_i = '0;
  logic         busy_o, done_o, timeout_err_o, crc_err_o, end_bit_err_o, index_err_o, cmd_en_o, cmd_o;
  logic [119:0] resp_o;
  logic         cmd_i = 1'b1;
  int total = 0;
  int bad = 0;
  logic [47:0]  frame;
  int           done_cyc;
  bit           en_bad, rel_bad;
  logic [119:0] resp_d;
  logic [3:0]   err_d;
  logic         busy_d;
  logic [119:0] cid = 120'h1D41444D5344202010A0B0C0D0E0F1;

  sd_cmd_host dut (
    .sd_clk_i(clk), .rst_i(rst_i), .start_i(start_i), .cmd_index_i(cmd_index_i),
    .cmd_arg_i(cmd_arg_i), .resp_type_i(resp_type_i), .busy_o(busy_o), .done_o(done_o),
    .resp_o(resp_o), .timeout_err_o(timeout_err_o), .crc_err_o(crc_err_o),
    .end_bit_err_o(end_bit_err_o), .index_err_o(index_err_o), .cmd_en_o(cmd_en_o),
    .cmd_o(cmd_o), .cmd_i(cmd_i)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] crc7_f(input logic [119:0] d, input int n);
    logic [6:0] c = '0;
    for (int i = n - 1; i >= 0; i--) c = {c[5:0], 1'b0} ^ ((c[6] ^ d[i]) ? 7'h09 : 7'h00);
    return c;
  endfunction

  function automatic logic [135:0] r48(input logic [39:0] d);
    logic [47:0] f = {d, crc7_f({80'd0, d}, 40), 1'b1};
    return {88'd0, f};
  endfunction

  task automatic do_cmd(input logic [5:0] ci, input logic [31:0] ca, input logic [1:0] rt,
                        input int rlen, input logic [135:0] rb, input int delay);
    int p;
    en_bad = 0; rel_bad = 0; done_cyc = -1; frame = '0;
    @(posedge clk); #1;
    start_i = 1'b1; cmd_index_i = ci; cmd_arg_i = ca; resp_type_i = rt;
    for (int k = 1; k <= 48; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      cmd_i = k[0];
      frame = {frame[46:0], cmd_o};
      if (!cmd_en_o) en_bad = 1;
    end
    for (int c = 49; c < 400; c++) begin
      @(posedge clk); #1;
      p = c - 49 - delay;
      cmd_i = (rlen > 0 && p >= 0 && p < rlen) ? rb[rlen - 1 - p] : 1'b1;
      if (cmd_en_o) en_bad = 1;
      if (!cmd_o) rel_bad = 1;
      if (done_o) begin
        done_cyc = c;
        resp_d = resp_o;
        err_d = {timeout_err_o, crc_err_o, end_bit_err_o, index_err_o};
        busy_d = busy_o;
        break;
      end
    end
    cmd_i = 1'b1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy_o, done_o, cmd_en_o, cmd_o, timeout_err_o, crc_err_o, end_bit_err_o, index_err_o} !== 8'b0001_0000) begin
      bad++; $display("FAIL reset_outs: got %b want 00010000",
        {busy_o, done_o, cmd_en_o, cmd_o, timeout_err_o, crc_err_o, end_bit_err_o, index_err_o});
    end
    total++;
    if (resp_o !== 120'd0) begin bad++; $display("FAIL reset_resp: got %h want 0", resp_o); end
    rst_i = 1'b0;
  endtask

  task automatic test_cmd0;
    do_cmd(6'd0, 32'h0, 2'b00, 0, '0, 0);
    total++;
    if (frame !== 48'h400000000095) begin bad++; $display("FAIL cmd0_frame: got %h want 400000000095", frame); end
    total++;
    if ({en_bad, rel_bad} !== 2'b00) begin bad++; $display("FAIL cmd0_release: got %b want 00", {en_bad, rel_bad}); end
    total++;
    if (done_cyc !== 57) begin bad++; $display("FAIL cmd0_done_cycle: got %0d want 57", done_cyc); end
    total++;
    if ({busy_d, err_d} !== 5'b1_0000) begin bad++; $display("FAIL cmd0_busy_err: got %b want 10000", {busy_d, err_d}); end
  endtask

  task automatic test_cmd8;
    do_cmd(6'd8, 32'h1AA, 2'b01, 48, 136'h08000001AA13, 5);
    total++;
    if (frame !== 48'h48000001AA87) begin bad++; $display("FAIL cmd8_frame: got %h want 48000001AA87", frame); end
    total++;
    if (done_cyc !== 110) begin bad++; $display("FAIL cmd8_done_cycle: got %0d want 110", done_cyc); end
    total++;
    if (resp_d !== 120'h1AA) begin bad++; $display("FAIL cmd8_resp: got %h want 1aa", resp_d); end
    total++;
    if (err_d !== 4'b0000) begin bad++; $display("FAIL cmd8_err: got %b want 0000", err_d); end
    total++;
    if ({en_bad, rel_bad} !== 2'b00) begin bad++; $display("FAIL cmd8_release: got %b want 00", {en_bad, rel_bad}); end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (resp_o !== 120'h1AA) begin bad++; $display("FAIL cmd8_resp_hold: got %h want 1aa", resp_o); end
  endtask

  task automatic test_crc_err;
    do_cmd(6'd8, 32'h1AA, 2'b01, 48, 136'h08000001AA13 ^ 136'h2, 3);
    total++;
    if (err_d !== 4'b0100) begin bad++; $display("FAIL crc_err_flags: got %b want 0100", err_d); end
  endtask

  task automatic test_index_err;
    do_cmd(6'd8, 32'h1AA, 2'b01, 48, r48({2'b00, 6'd9, 32'h1AA}), 4);
    total++;
    if (err_d !== 4'b0001) begin bad++; $display("FAIL index_err_r48: got %b want 0001", err_d); end
    do_cmd(6'd8, 32'h1AA, 2'b10, 48, r48({2'b00, 6'd9, 32'h1AA}), 4);
    total++;
    if (err_d !== 4'b0000) begin bad++; $display("FAIL index_err_nocrc: got %b want 0000", err_d); end
    total++;
    if (resp_d !== 120'h1AA) begin bad++; $display("FAIL index_nocrc_resp: got %h want 1aa", resp_d); end
    do_cmd(6'd41, 32'h0, 2'b10, 48, 136'h3F00FF800012, 1);
    total++;
    if (err_d !== 4'b0010) begin bad++; $display("FAIL end_bit_err: got %b want 0010", err_d); end
    total++;
    if (resp_d !== 120'h00FF8000) begin bad++; $display("FAIL r3_resp: got %h want 00ff8000", resp_d); end
  endtask

  task automatic test_timeout;
    do_cmd(6'd2, 32'h0, 2'b01, 0, '0, 0);
    total++;
    if (done_cyc !== 113) begin bad++; $display("FAIL timeout_done_cycle: got %0d want 113", done_cyc); end
    total++;
    if (err_d !== 4'b1000) begin bad++; $display("FAIL timeout_flags: got %b want 1000", err_d); end
    total++;
    if (en_bad !== 1'b0) begin bad++; $display("FAIL timeout_cmd_en: got %b want 0", en_bad); end
  endtask

  task automatic test_r136;
    logic [135:0] rb;
    rb = {8'h3F, cid, crc7_f(cid, 120), 1'b1};
    do_cmd(6'd2, 32'h0, 2'b11, 136, rb, 2);
    total++;
    if (done_cyc !== 195) begin bad++; $display("FAIL r136_done_cycle: got %0d want 195", done_cyc); end
    total++;
    if (resp_d !== cid) begin bad++; $display("FAIL r136_resp: got %h want %h", resp_d, cid); end
    total++;
    if (err_d !== 4'b0000) begin bad++; $display("FAIL r136_err: got %b want 0000", err_d); end
  endtask

  task automatic test_back_to_back;
    logic [2:0] seen;
    bit got;
    seen = '0; got = 0;
    @(posedge clk); #1;
    start_i = 1'b1; cmd_index_i = 6'd0; cmd_arg_i = 32'h0; resp_type_i = 2'b00;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (c == 57) seen[2] = done_o;
      if (c == 58) seen[1] = busy_o;
      if (c == 59) seen[0] = busy_o & cmd_en_o & ~cmd_o;
    end
    start_i = 1'b0;
    total++;
    if (seen !== 3'b101) begin bad++; $display("FAIL b2b_done_idle_accept: got %b want 101", seen); end
    for (int c = 61; c < 200; c++) begin
      @(posedge clk); #1;
      if (done_o) begin got = 1; break; end
    end
    total++;
    if (got !== 1'b1) begin bad++; $display("FAIL b2b_second_done: got %b want 1", got); end
  endtask

  task automatic test_reset_mid_tx;
    bit saw_done;
    logic en_mid;
    saw_done = 0;
    @(posedge clk); #1;
    start_i = 1'b1; cmd_index_i = 6'd17; cmd_arg_i = 32'hDEADBEEF; resp_type_i = 2'b01;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    en_mid = cmd_en_o;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    total++;
    if ({en_mid, cmd_en_o, busy_o, done_o, cmd_o} !== 5'b10001) begin
      bad++; $display("FAIL mid_tx_reset: got %b want 10001", {en_mid, cmd_en_o, busy_o, done_o, cmd_o});
    end
    for (int c = 0; c < 80; c++) begin
      @(posedge clk); #1;
      if (done_o || busy_o) saw_done = 1;
    end
    total++;
    if (saw_done !== 1'b0) begin bad++; $display("FAIL mid_tx_no_done: got %b want 0", saw_done); end
  endtask

  initial begin
    test_reset;
    test_cmd0;
    test_cmd8;
    test_crc_err;
    test_index_err;
    test_timeout;
    test_r136;
    test_back_to_back;
    test_reset_mid_tx;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
